// File: rtl/reg_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback_sequencer
// Purpose  : Write-side initiator for the 32x32 CPU register file. Merges
//            ALU and mult/div writeback requests into a DEPTH-entry FIFO,
//            issues at most one register-file write per cycle, and publishes
//            a per-register pending scoreboard for RAW-hazard stalls.
// Ports    : clk, reset (async, active-high), flush (sync discard)
//            alu_valid/alu_addr/alu_data/alu_ready : ALU writeback request
//            md_valid/md_addr/md_data/md_ready     : mult/div request (priority)
//            rf_write_enable/address/data          : registered RF write port
//            pending[31:0]                         : outstanding-write scoreboard
//            fifo_count                            : valid FIFO entries
//            WB_FORWARD_EN only: fwd_addr_1/2 in, fwd_hit_1/2, fwd_data_1/2 out
// Config   : `define WB_FORWARD_EN to add the combinational forwarding ports.
// Revision : 1.0 - initial release
// ============================================================================
module reg_writeback_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_addr,
  input  logic [31:0]                alu_data,
  output logic                       alu_ready,
  input  logic                       md_valid,
  input  logic [4:0]                 md_addr,
  input  logic [31:0]                md_data,
  output logic                       md_ready,
  output logic                       rf_write_enable,
  output logic [4:0]                 rf_write_address,
  output logic [31:0]                rf_write_data,
  output logic [31:0]                pending,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
`ifdef WB_FORWARD_EN
  ,
  input  logic [4:0]                 fwd_addr_1,
  input  logic [4:0]                 fwd_addr_2,
  output logic                       fwd_hit_1,
  output logic                       fwd_hit_2,
  output logic [31:0]                fwd_data_1,
  output logic [31:0]                fwd_data_2
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [4:0]       addr_q [DEPTH];
  logic [4:0]       addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_addr_q, rf_addr_d;
  logic [31:0]      rf_data_q, rf_data_d;

  logic             full;
  logic             empty;
  logic             accept;
  logic             push;
  logic             pop;
  logic [4:0]       push_addr;
  logic [31:0]      push_data;
  logic [PTR_W-1:0] pend_idx;

  // Handshake: full reflects the start-of-cycle occupancy, so a same-cycle
  // pop never makes room for a push.
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    md_ready  = !reset && !full && !flush;
    alu_ready = md_ready && !md_valid;
    push_addr = md_valid ? md_addr : alu_addr;
    push_data = md_valid ? md_data : alu_data;
    accept    = (md_valid && md_ready) || (alu_valid && alu_ready);
    // r0 writes complete the handshake but are dropped here.
    push      = accept && (push_addr != 5'd0);
    pop       = !empty && !flush;
  end

  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rf_we_d   = 1'b1;
        rf_addr_d = addr_q[rd_ptr_q];
        rf_data_d = data_q[rd_ptr_q];
        rd_ptr_d  = rd_ptr_q + 1'b1;
      end
      if (push) begin
        addr_d[wr_ptr_q] = push_addr;
        data_d[wr_ptr_q] = push_data;
        wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Scoreboard: every live FIFO slot (offset from head below count) plus the
  // issuing stage marks its destination.
  always_comb begin
    pending  = '0;
    pend_idx = '0;
    if (rf_we_q) pending[rf_addr_q] = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      pend_idx = rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < count_q) pending[addr_q[pend_idx]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign rf_write_enable  = rf_we_q;
  assign rf_write_address = rf_addr_q;
  assign rf_write_data    = rf_data_q;
  assign fifo_count       = count_q;

`ifdef WB_FORWARD_EN
  // Search oldest to youngest (rf stage, then FIFO head..tail) so the last
  // match overwrites and the youngest write wins.
  for (genvar p = 0; p < 2; p++) begin : g_fwd
    logic [4:0]       a;
    logic             hit;
    logic [31:0]      data;
    logic [PTR_W-1:0] idx;
    assign a = (p == 0) ? fwd_addr_1 : fwd_addr_2;
    always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      if (!reset && (a != 5'd0)) begin
        if (rf_we_q && (rf_addr_q == a)) begin
          hit  = 1'b1;
          data = rf_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
          idx = rd_ptr_q + PTR_W'(k);
          if ((CNT_W'(k) < count_q) && (addr_q[idx] == a)) begin
            hit  = 1'b1;
            data = data_q[idx];
          end
        end
      end
    end
  end

  assign fwd_hit_1  = g_fwd[0].hit;
  assign fwd_data_1 = g_fwd[0].data;
  assign fwd_hit_2  = g_fwd[1].hit;
  assign fwd_data_2 = g_fwd[1].data;
`endif

endmodule
`default_nettype wire
